// File: rtl/axi_rd_burst_sched.sv
// axi_rd_burst_sched
//   Round-robin scheduler that shares one AXI4 read master port between PORTS
//   requesters. A winning descriptor (address, ARLEN) is registered, issued on
//   AR, and the returning R beats are steered to the winner only. One burst is
//   in flight at a time; the grant is held until the RLAST handshake.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req_valid/ready     per-requester descriptor handshake (ready is one-hot)
//   req_addr, req_len   packed per-requester address / ARLEN slices
//   rd_data, rd_last    R data/last, shared by all requesters (pass-through)
//   rd_valid, rd_ready  per-requester R handshake; only the grantee sees valid
//   m_axi_ar*           AXI AR channel (INCR, full-width beats)
//   m_axi_r*            AXI R channel
//   grant_idx           current / most recent winner
//   busy                a burst is being issued or received
//   len_err, resp_err   one-cycle error pulses (beat count, non-OKAY rresp)

module axi_rd_burst_sched #(
  parameter int PORTS      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PORTS-1:0]            req_valid,
  output logic [PORTS-1:0]            req_ready,
  input  logic [PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [PORTS*8-1:0]          req_len,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic                        rd_last,
  output logic [PORTS-1:0]            rd_valid,
  input  logic [PORTS-1:0]            rd_ready,
  output logic [ADDR_WIDTH-1:0]       m_axi_araddr,
  output logic [7:0]                  m_axi_arlen,
  output logic [2:0]                  m_axi_arsize,
  output logic [1:0]                  m_axi_arburst,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  input  logic [DATA_WIDTH-1:0]       m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rlast,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready,
  output logic [$clog2(PORTS)-1:0]    grant_idx,
  output logic                        busy,
  output logic                        len_err,
  output logic                        resp_err
);

  localparam int GW = $clog2(PORTS);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                  state_reg, state_next;
  logic [GW-1:0]           rr_ptr_reg, rr_ptr_next;
  logic [GW-1:0]           grant_idx_reg, grant_idx_next;
  logic [ADDR_WIDTH-1:0]   araddr_reg, araddr_next;
  logic [7:0]              arlen_reg, arlen_next;
  logic [8:0]              beat_cnt_reg, beat_cnt_next;
  logic                    len_err_reg, len_err_next;
  logic                    resp_err_reg, resp_err_next;

  logic [ADDR_WIDTH-1:0]   addr_arr [PORTS];
  logic [7:0]              len_arr  [PORTS];
  logic [GW-1:0]           win_idx;
  logic                    win_found;
  logic                    r_hs;

  // Unpack the flat descriptor buses and build the per-port handshake outputs.
  for (genvar gi = 0; gi < PORTS; gi++) begin : g_port
    assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign len_arr[gi]   = req_len[gi*8 +: 8];
    assign req_ready[gi] = (state_reg == IDLE) && win_found && (win_idx == GW'(gi));
    assign rd_valid[gi]  = (state_reg == DATA) && (grant_idx_reg == GW'(gi)) && m_axi_rvalid;
  end

  // Round-robin search: first requesting port at or above rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx       = 0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = 0; k < PORTS; k++) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= PORTS) idx = idx - PORTS;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = GW'(idx);
      end
    end
  end

  assign m_axi_rready = (state_reg == DATA) && rd_ready[grant_idx_reg];
  assign r_hs         = m_axi_rready && m_axi_rvalid;

  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    grant_idx_next = grant_idx_reg;
    araddr_next    = araddr_reg;
    arlen_next     = arlen_reg;
    beat_cnt_next  = beat_cnt_reg;
    len_err_next   = 1'b0;
    resp_err_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          araddr_next    = addr_arr[win_idx];
          arlen_next     = len_arr[win_idx];
          grant_idx_next = win_idx;
          rr_ptr_next    = (win_idx == GW'(PORTS - 1)) ? '0 : win_idx + GW'(1);
          state_next     = ADDR;
        end
      end
      ADDR: begin
        if (m_axi_arready) begin
          beat_cnt_next = '0;
          state_next    = DATA;
        end
      end
      DATA: begin
        if (r_hs) begin
          beat_cnt_next = beat_cnt_reg + 9'd1;
          resp_err_next = (m_axi_rresp != 2'b00);
          // beat_cnt counts beats already taken, so the last beat must see
          // beat_cnt == arlen; anything past arlen without RLAST is also bad.
          if (m_axi_rlast) begin
            len_err_next = (beat_cnt_reg != {1'b0, arlen_reg});
            state_next   = IDLE;
          end else begin
            len_err_next = (beat_cnt_reg > {1'b0, arlen_reg});
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      grant_idx_reg <= '0;
      araddr_reg    <= '0;
      arlen_reg     <= '0;
      beat_cnt_reg  <= '0;
      len_err_reg   <= 1'b0;
      resp_err_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      grant_idx_reg <= grant_idx_next;
      araddr_reg    <= araddr_next;
      arlen_reg     <= arlen_next;
      beat_cnt_reg  <= beat_cnt_next;
      len_err_reg   <= len_err_next;
      resp_err_reg  <= resp_err_next;
    end
  end

  assign rd_data       = m_axi_rdata;
  assign rd_last       = m_axi_rlast;
  assign m_axi_araddr  = araddr_reg;
  assign m_axi_arlen   = arlen_reg;
  assign m_axi_arsize  = 3'($clog2(DATA_WIDTH / 8));
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = (state_reg == ADDR);
  assign grant_idx     = grant_idx_reg;
  assign busy          = (state_reg != IDLE);
  assign len_err       = len_err_reg;
  assign resp_err      = resp_err_reg;

endmodule
